uart8_rx_controller: RTL and testbench

Sequencing and buffering controller for the 8-bit UART receiver, running on the same 16x-oversampled rx clock. It drives the receiver's enable and captures each received byte once per `done` pulse into a small FIFO with a valid/ready output. It also counts receive errors, restarts the receiver after repeated consecutive errors, and flags end-of-burst line idle.

---
 rtl/uart8_rx_controller_pkg.sv | 38 +++
 rtl/uart8_rx_controller_fifo.sv | 96 +++++++++
 rtl/uart8_rx_controller.sv | 230 +++++++++++++++++++++++
 tb/tb_uart8_rx_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart8_rx_controller_pkg.sv
// ---------------------------------------------------------------------------
// uart8_rx_controller_pkg
// Shared types and helpers for the UART receive controller:
//   - ctrl_state_e : controller FSM encodings (OFF, RUN, RESTART)
//   - counter widths and saturation limits
//   - saturating increment helpers for the error counters
// ---------------------------------------------------------------------------
package uart8_rx_controller_pkg;

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RUN     = 2'd1,
        ST_RESTART = 2'd2
    } ctrl_state_e;

    localparam int         IDLE_CNT_W     = 10;
    localparam logic [7:0] ERR_COUNT_MAX  = 8'd255;
    localparam logic [3:0] CONS_COUNT_MAX = 4'd15;

    // Total error counter: holds at its maximum instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == ERR_COUNT_MAX) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

    // Consecutive error counter: holds at its maximum instead of wrapping.
    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        if (value == CONS_COUNT_MAX) begin
            return value;
        end else begin
            return value + 4'd1;
        end
    endfunction

endpackage

// File: rtl/uart8_rx_controller_fifo.sv
// ---------------------------------------------------------------------------
// uart8_rx_controller_fifo
// Synchronous first-word-fall-through FIFO with a registered head.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full unless popping in the same cycle)
//   wdata    : byte to store
//   pop      : remove the head entry (ignored when empty)
//   rdata    : registered head entry, zero whenever the FIFO is empty
//   valid    : FIFO holds at least one entry
//   full     : FIFO holds DEPTH entries
// A push into an empty FIFO shows up on rdata one cycle later; there is no
// combinational pass-through from wdata to rdata.
// ---------------------------------------------------------------------------
module uart8_rx_controller_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);
    localparam int           AW      = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_L = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_next_s;
    logic [AW-1:0]    rd_ptr_next_s;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic [WIDTH-1:0] head_next_s;
    logic [WIDTH-1:0] rdata_r;
    logic             valid_r;

    assign full      = (count_r == DEPTH_L);
    assign pop_ok_s  = pop && (count_r != {(AW + 1){1'b0}});
    // When full, a push is only accepted if the head leaves in the same cycle.
    assign push_ok_s = push && (!full || pop_ok_s);

    assign count_next_s  = count_r + (AW + 1)'(push_ok_s) - (AW + 1)'(pop_ok_s);
    assign rd_ptr_next_s = rd_ptr_r + AW'(pop_ok_s);

    // Next head value: empty gives zero; the slot being written this cycle
    // becomes the head only when it lands exactly at the new read pointer.
    always_comb begin
        head_next_s = {WIDTH{1'b0}};
        if (count_next_s == {(AW + 1){1'b0}}) begin
            head_next_s = {WIDTH{1'b0}};
        end else if (push_ok_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = wdata;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers, occupancy and registered head/valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
            rdata_r  <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            rdata_r  <= head_next_s;
            valid_r  <= (count_next_s != {(AW + 1){1'b0}});
        end
    end

    assign rdata = rdata_r;
    assign valid = valid_r;

endmodule

// File: rtl/uart8_rx_controller.sv
// ---------------------------------------------------------------------------
// uart8_rx_controller
// Sequencing and buffering controller for the 8-bit UART receiver, clocked
// by the 16x-oversampled rx clock.
//   clk, rst  : rx clock, asynchronous active-high reset
//   enable    : software enable for reception
//   clear     : clears err_count and overflow (wins over same-cycle updates)
//   rx_busy   : receiver busy, used only for idle timing
//   rx_done   : receiver done level (16 ticks per byte), one push per pulse
//   rx_err    : receiver error level, rising edges counted in RUN only
//   rx_out    : receiver parallel data, sampled on the rx_done rising edge
//   rx_en     : registered receiver enable
//   data/valid/ready : FIFO head with valid/ready handshake
//   idle      : one-tick pulse after a burst once the line stays quiet
//   overflow  : sticky, a byte was dropped on a full FIFO
//   err_count : saturating total of counted error edges
// ---------------------------------------------------------------------------
module uart8_rx_controller
    import uart8_rx_controller_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int ERR_LIMIT     = 3,
    parameter int RESTART_TICKS = 2,
    parameter int IDLE_TICKS    = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic [7:0] rx_out,
    output logic       rx_en,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       idle,
    output logic       overflow,
    output logic [7:0] err_count
);
    localparam logic [3:0]            ERR_LIMIT_L     = 4'(ERR_LIMIT);
    localparam logic [3:0]            RESTART_TICKS_L = 4'(RESTART_TICKS);
    localparam logic [IDLE_CNT_W-1:0] IDLE_LAST_L     = IDLE_CNT_W'(IDLE_TICKS - 1);

    ctrl_state_e           state_r;
    ctrl_state_e           state_next_s;
    logic                  restart_load_s;
    logic [3:0]            restart_cnt_r;
    logic                  rx_en_r;
    logic                  done_prev_r;
    logic                  err_prev_r;
    logic                  done_edge_s;
    logic                  err_edge_s;
    logic                  in_run_s;
    logic                  push_s;
    logic                  err_hit_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_valid_s;
    logic [7:0]            fifo_data_s;
    logic [3:0]            cons_err_r;
    logic [7:0]            err_count_r;
    logic                  overflow_r;
    logic [IDLE_CNT_W-1:0] idle_cnt_r;
    logic                  armed_r;
    logic                  idle_r;

    assign in_run_s    = (state_r == ST_RUN);
    assign done_edge_s = rx_done && !done_prev_r;
    assign err_edge_s  = rx_err && !err_prev_r;
    assign push_s      = done_edge_s && in_run_s;
    // Errors outside RUN are ignored: the level may persist across a restart.
    assign err_hit_s   = err_edge_s && in_run_s;
    assign pop_s       = fifo_valid_s && ready;

    // Next-state logic for the receiver sequencing FSM.
    always_comb begin
        state_next_s   = state_r;
        restart_load_s = 1'b0;
        case (state_r)
            ST_OFF: begin
                if (enable) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_OFF;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_next_s = ST_OFF;
                end else if (cons_err_r >= ERR_LIMIT_L) begin
                    state_next_s   = ST_RESTART;
                    restart_load_s = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_RESTART: begin
                // Counter is loaded on entry, so leaving at 1 gives exactly
                // RESTART_TICKS cycles with rx_en low.
                if (restart_cnt_r <= 4'd1) begin
                    if (enable) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_OFF;
                    end
                end else begin
                    state_next_s = ST_RESTART;
                end
            end
            default: begin
                state_next_s = ST_OFF;
            end
        endcase
    end

    // State register and registered receiver enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_OFF;
            rx_en_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            rx_en_r <= (state_next_s == ST_RUN);
        end
    end

    // Restart hold-off counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            restart_cnt_r <= 4'd0;
        end else if (restart_load_s) begin
            restart_cnt_r <= RESTART_TICKS_L;
        end else if ((state_r == ST_RESTART) && (restart_cnt_r != 4'd0)) begin
            restart_cnt_r <= restart_cnt_r - 4'd1;
        end
    end

    // Previous-value registers for rx_done / rx_err edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_prev_r <= 1'b0;
            err_prev_r  <= 1'b0;
        end else begin
            done_prev_r <= rx_done;
            err_prev_r  <= rx_err;
        end
    end

    // Consecutive error count: cleared by a good byte or a restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cons_err_r <= 4'd0;
        end else if (restart_load_s || push_s) begin
            cons_err_r <= 4'd0;
        end else if (err_hit_s) begin
            cons_err_r <= sat_inc4(cons_err_r);
        end
    end

    // Saturating total error count and sticky overflow, both cleared by clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count_r <= 8'd0;
            overflow_r  <= 1'b0;
        end else if (clear) begin
            err_count_r <= 8'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (err_hit_s) begin
                err_count_r <= sat_inc8(err_count_r);
            end
            if (push_s && fifo_full_s && !pop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // End-of-burst idle timer: armed by a push, disarmed by its pulse or by
    // leaving RUN, restarted whenever the receiver reports busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt_r <= {IDLE_CNT_W{1'b0}};
            armed_r    <= 1'b0;
            idle_r     <= 1'b0;
        end else begin
            idle_r <= 1'b0;
            if (push_s) begin
                idle_cnt_r <= {IDLE_CNT_W{1'b0}};
                armed_r    <= 1'b1;
            end else if (!in_run_s) begin
                idle_cnt_r <= {IDLE_CNT_W{1'b0}};
                armed_r    <= 1'b0;
            end else if (rx_busy) begin
                idle_cnt_r <= {IDLE_CNT_W{1'b0}};
            end else if (armed_r) begin
                if (idle_cnt_r == IDLE_LAST_L) begin
                    idle_r     <= 1'b1;
                    armed_r    <= 1'b0;
                    idle_cnt_r <= {IDLE_CNT_W{1'b0}};
                end else begin
                    idle_cnt_r <= idle_cnt_r + {{(IDLE_CNT_W - 1){1'b0}}, 1'b1};
                end
            end
        end
    end

    uart8_rx_controller_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (rx_out),
        .pop   (pop_s),
        .rdata (fifo_data_s),
        .valid (fifo_valid_s),
        .full  (fifo_full_s)
    );

    assign rx_en     = rx_en_r;
    assign data      = fifo_data_s;
    assign valid     = fifo_valid_s;
    assign idle      = idle_r;
    assign overflow  = overflow_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_uart8_rx_controller.sv
// ---------------------------------------------------------------------------
// tb_uart8_rx_controller
// Directed bench for uart8_rx_controller with default parameters
// (FIFO_DEPTH=4, ERR_LIMIT=3, RESTART_TICKS=2, IDLE_TICKS=160).
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_uart8_rx_controller;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       clear;
    logic       rx_busy;
    logic       rx_done;
    logic       rx_err;
    logic [7:0] rx_out;
    logic       rx_en;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       idle;
    logic       overflow;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    uart8_rx_controller dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .clear     (clear),
        .rx_busy   (rx_busy),
        .rx_done   (rx_done),
        .rx_err    (rx_err),
        .rx_out    (rx_out),
        .rx_en     (rx_en),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .idle      (idle),
        .overflow  (overflow),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One received byte: rx_done high for 16 ticks, then one low tick.
    task automatic send_byte(input logic [7:0] b);
        rx_out  = b;
        rx_done = 1'b1;
        repeat (16) tick();
        rx_done = 1'b0;
        tick();
    endtask

    task automatic err_pulse();
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; rx_busy = 1'b0;
        rx_done = 1'b0; rx_err = 1'b0; rx_out = 8'h00; ready = 1'b0;
        #1;
        chk("rst_rx_en", rx_en, 1'b0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_data", data, 8'h00);
        chk("rst_idle", idle, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_err_count", err_count, 8'h00);
        tick();
        rst = 1'b0;
        tick();
        chk("off_rx_en", rx_en, 1'b0);

        // Enable and single byte A5.
        enable = 1'b1;
        tick();
        chk("en_rx_en", rx_en, 1'b1);
        rx_out  = 8'hA5;
        rx_done = 1'b1;
        tick();
        chk("a5_valid", valid, 1'b1);
        chk("a5_data", data, 8'hA5);
        repeat (15) tick();
        rx_done = 1'b0;
        tick();
        chk("a5_hold_data", data, 8'hA5);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("a5_pop_valid", valid, 1'b0);
        chk("a5_pop_data", data, 8'h00);

        // Overflow: five bytes into a four-deep FIFO.
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        chk("ovf_flag", overflow, 1'b1);
        chk("ovf_head", data, 8'h01);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("ovf_clear", overflow, 1'b0);
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_valid", valid, 1'b1);
            chk("drain_data", data, 32'(i));
            tick();
        end
        ready = 1'b0;
        chk("drain_empty_valid", valid, 1'b0);
        chk("drain_empty_data", data, 8'h00);

        // Push and pop in the same cycle while full: accepted, no overflow.
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
        rx_out  = 8'h14;
        rx_done = 1'b1;
        ready   = 1'b1;
        tick();
        ready = 1'b0;
        chk("fullpop_head", data, 8'h11);
        chk("fullpop_ovf", overflow, 1'b0);
        repeat (15) tick();
        rx_done = 1'b0;
        tick();
        ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("fullpop_drain", data, 32'h10 + 32'(i));
            tick();
        end
        ready = 1'b0;
        chk("fullpop_empty", valid, 1'b0);

        // Three consecutive errors trigger a 2-cycle restart.
        err_pulse();
        err_pulse();
        rx_err = 1'b1;
        tick();
        chk("err3_rx_en_still_high", rx_en, 1'b1);
        chk("err3_count", err_count, 8'd3);
        rx_err = 1'b0;
        tick();
        chk("restart_low1", rx_en, 1'b0);
        rx_err = 1'b1;
        tick();
        chk("restart_low2", rx_en, 1'b0);
        tick();
        chk("restart_back_high", rx_en, 1'b1);
        chk("restart_err_ignored", err_count, 8'd3);
        rx_err = 1'b0;
        tick();

        // A good byte breaks the consecutive-error run.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_err_count", err_count, 8'd0);
        err_pulse();
        send_byte(8'h5A);
        err_pulse();
        err_pulse();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("norestart_rx_en", rx_en, 1'b1);
        end
        chk("norestart_err_count", err_count, 8'd3);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("norestart_drained", valid, 1'b0);

        // Idle pulse exactly 160 ticks after the push, and only once.
        send_byte(8'h33);
        for (int t = 17; t <= 220; t++) begin
            tick();
            chk("idle_pulse", idle, 32'(t == 160));
        end

        // rx_busy rising at tick 100 suppresses the pulse.
        send_byte(8'h44);
        for (int t = 17; t <= 200; t++) begin
            if (t == 100) rx_busy = 1'b1;
            tick();
            chk("idle_suppressed", idle, 1'b0);
        end

        // Asynchronous reset mid-burst with two bytes queued.
        chk("prerst_head", data, 8'h33);
        chk("prerst_errs", err_count, 8'd3);
        rx_out  = 8'h55;
        rx_done = 1'b1;
        repeat (3) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rx_en", rx_en, 1'b0);
        chk("arst_valid", valid, 1'b0);
        chk("arst_data", data, 8'h00);
        chk("arst_err_count", err_count, 8'h00);
        chk("arst_overflow", overflow, 1'b0);
        chk("arst_idle", idle, 1'b0);
        rx_done = 1'b0;
        rx_busy = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("postrst_empty", valid, 1'b0);
        chk("postrst_rx_en", rx_en, 1'b1);

        // Dropping enable: rx_en low next cycle, queued bytes still drain.
        send_byte(8'h66);
        send_byte(8'h77);
        enable = 1'b0;
        tick();
        chk("disable_rx_en", rx_en, 1'b0);
        send_byte(8'h88);
        ready = 1'b1;
        chk("off_drain0_valid", valid, 1'b1);
        chk("off_drain0", data, 8'h66);
        tick();
        chk("off_drain1", data, 8'h77);
        tick();
        ready = 1'b0;
        chk("off_no_push", valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
